// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared definitions for the iterative RV M-extension unit.
//               Holds the funct3 op-select codes, the FSM state encoding,
//               and the operand-signedness decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    // funct3 op-select codes, shared with the execute-stage ALU decode
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Divide and remainder ops all have funct3[2] set
    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    // op1 is signed for MUL, MULH, MULHSU, DIV and REM
    function automatic logic is_signed_op1(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

    // op2 is signed for MUL, MULH, DIV and REM
    function automatic logic is_signed_op2(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_MULH) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage : muldiv_pkg
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_step
// Description : Combinational ITER_PER_CYCLE-deep chain of shift-add
//               (multiply) or restoring (divide) iteration steps.
//               Multiply: {acc[XLEN-1:0], lo} is the 2*XLEN product register,
//               lo initially holds the multiplier, opb the multiplicand.
//               Divide: acc is the XLEN+1 bit partial remainder, lo shifts
//               the dividend out and the quotient in, opb is the divisor.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_step #(
    parameter int XLEN           = 32,
    parameter int ITER_PER_CYCLE = 1
) (
    input  logic            is_div_i,
    input  logic [XLEN:0]   acc_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic [XLEN-1:0] opb_i,
    output logic [XLEN:0]   acc_o,
    output logic [XLEN-1:0] lo_o
);

    logic [XLEN:0]   w_acc [ITER_PER_CYCLE+1];
    logic [XLEN-1:0] w_lo  [ITER_PER_CYCLE+1];

    assign w_acc[0] = acc_i;
    assign w_lo[0]  = lo_i;

    for (genvar g = 0; g < ITER_PER_CYCLE; g++) begin : g_iter
        logic [XLEN:0] w_sum;
        logic [XLEN:0] w_shift;
        logic [XLEN:0] w_diff;

        // Multiply: add multiplicand when the current multiplier bit is set,
        // then shift the whole product register right by one.
        assign w_sum   = w_acc[g] + (w_lo[g][0] ? {1'b0, opb_i} : '0);
        // Divide: bring the next dividend bit into the partial remainder and
        // trial-subtract; a set MSB means the subtraction went negative.
        assign w_shift = {w_acc[g][XLEN-1:0], w_lo[g][XLEN-1]};
        assign w_diff  = w_shift - {1'b0, opb_i};

        assign w_acc[g+1] = is_div_i ? (w_diff[XLEN] ? w_shift : w_diff)
                                     : {1'b0, w_sum[XLEN:1]};
        assign w_lo[g+1]  = is_div_i ? {w_lo[g][XLEN-2:0], ~w_diff[XLEN]}
                                     : {w_sum[0], w_lo[g][XLEN-1:1]};
    end

    assign acc_o = w_acc[ITER_PER_CYCLE];
    assign lo_o  = w_lo[ITER_PER_CYCLE];

endmodule : muldiv_step
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Multi-cycle RV32M/RV64M multiply/divide/remainder unit with
//               valid/ready handshakes. Operands are converted to magnitudes
//               on accept, iterated in CALC, sign-corrected in FIX and held
//               in DONE until the consumer takes the result.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int XLEN           = 32,
    parameter int ITER_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op_select,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    import muldiv_pkg::*;

    localparam int                c_STEPS = XLEN / ITER_PER_CYCLE;
    localparam int                c_CNT_W = $clog2(c_STEPS);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_STEPS - 1);
    localparam logic [XLEN-1:0]   c_MIN   = {1'b1, {(XLEN-1){1'b0}}};

    state_t               state_q, state_d;
    logic [2:0]           op_q;
    logic                 neg_q;
    logic [XLEN:0]        acc_q;
    logic [XLEN-1:0]      lo_q;
    logic [XLEN-1:0]      opb_q;
    logic [c_CNT_W-1:0]   cnt_q;
    logic [XLEN-1:0]      result_q;

    logic                 w_accept;
    logic                 w_is_div;
    logic                 w_s1, w_s2;
    logic [XLEN-1:0]      w_mag1, w_mag2;
    logic                 w_div_zero, w_ovf, w_special, w_neg;
    logic [XLEN-1:0]      w_special_res;
    logic [XLEN:0]        w_acc_next;
    logic [XLEN-1:0]      w_lo_next;
    logic [2*XLEN-1:0]    w_prod, w_prod_fix;
    logic [XLEN-1:0]      w_quo_fix, w_rem_fix, w_fix_res;

    // Handshake and status outputs
    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign result    = result_q;

    // A request arriving alongside flush is dropped
    assign w_accept = in_valid && in_ready && !flush;

    // Operand sign decode and magnitudes for the incoming request
    assign w_is_div = is_div(op_select);
    assign w_s1     = is_signed_op1(op_select) && op1[XLEN-1];
    assign w_s2     = is_signed_op2(op_select) && op2[XLEN-1];
    assign w_mag1   = w_s1 ? (XLEN'(0) - op1) : op1;
    assign w_mag2   = w_s2 ? (XLEN'(0) - op2) : op2;

    // Divide-by-zero and signed overflow resolve immediately without iterating
    assign w_div_zero = w_is_div && (op2 == '0);
    assign w_ovf      = w_is_div && !op_select[0] && (op1 == c_MIN) && (&op2);
    assign w_special  = w_div_zero || w_ovf;

    // Remainder ops take the sign of op1; everything else the XOR of both signs
    assign w_neg = (w_is_div && op_select[1]) ? w_s1 : (w_s1 ^ w_s2);

    // Special-case results: op_select[1] distinguishes REM/REMU from DIV/DIVU
    always_comb begin
        w_special_res = '0;
        if (w_div_zero) begin
            w_special_res = op_select[1] ? op1 : '1;
        end else if (w_ovf) begin
            w_special_res = op_select[1] ? '0 : op1;
        end
    end

    muldiv_step #(
        .XLEN           (XLEN),
        .ITER_PER_CYCLE (ITER_PER_CYCLE)
    ) u_step (
        .is_div_i (is_div(op_q)),
        .acc_i    (acc_q),
        .lo_i     (lo_q),
        .opb_i    (opb_q),
        .acc_o    (w_acc_next),
        .lo_o     (w_lo_next)
    );

    // Sign fix-up of the finished product, quotient and remainder
    assign w_prod     = {acc_q[XLEN-1:0], lo_q};
    assign w_prod_fix = neg_q ? ((2*XLEN)'(0) - w_prod) : w_prod;
    assign w_quo_fix  = neg_q ? (XLEN'(0) - lo_q) : lo_q;
    assign w_rem_fix  = neg_q ? (XLEN'(0) - acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];

    // Select which fixed-up field becomes the result
    always_comb begin
        w_fix_res = w_rem_fix;
        case (op_q)
            OP_MUL:                        w_fix_res = w_prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               w_fix_res = w_quo_fix;
            default:                       w_fix_res = w_rem_fix;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    state_d = w_special ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt_q == c_LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    if (w_accept) begin
                        state_d = w_special ? DONE : CALC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (flush) begin
            state_d = IDLE;
        end
    end

    // Datapath: latch operands on accept, iterate in CALC, write result in FIX
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= OP_MUL;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            lo_q     <= '0;
            opb_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            if (w_accept) begin
                op_q  <= op_select;
                neg_q <= w_neg;
                acc_q <= '0;
                cnt_q <= '0;
                // Multiply shifts the multiplier out of lo; divide shifts the
                // dividend out of lo. opb is the multiplicand or divisor.
                lo_q  <= w_is_div ? w_mag1 : w_mag2;
                opb_q <= w_is_div ? w_mag2 : w_mag1;
                if (w_special) begin
                    result_q <= w_special_res;
                end
            end else if (state_q == CALC) begin
                acc_q <= w_acc_next;
                lo_q  <= w_lo_next;
                cnt_q <= cnt_q + 1'b1;
            end
            if ((state_q == FIX) && !flush) begin
                result_q <= w_fix_res;
            end
        end
    end

endmodule : muldiv_unit
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Directed self-checking bench for muldiv_unit (XLEN=32,
//               ITER_PER_CYCLE=1). Latency is counted in clock edges from
//               the accepting edge (counted as 1) up to and including the
//               edge after which out_valid is high: 34 normal, 1 special.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    import muldiv_pkg::*;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op_select;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    muldiv_unit #(
        .XLEN           (32),
        .ITER_PER_CYCLE (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_select (op_select),
        .op1       (op1),
        .op2       (op2),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request, wait (bounded) for the result, then complete the handshake
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output bit timeout);
        @(negedge clk);
        in_valid = 1'b1; op_select = op; op1 = a; op2 = b; out_ready = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1 lat++;
        end
        timeout = !out_valid;
        res = result;
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        op_select = OP_MUL; op1 = '0; op2 = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || result !== 32'h0) begin
            failures++;
            $display("FAIL reset_state: busy=%b out_valid=%b result=%h required 0/0/00000000",
                     busy, out_valid, result);
        end
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_mul();
        logic [31:0] res; int lat; bit to;
        do_op(OP_MUL, 32'hFFFF_FFFF, 32'd7, res, lat, to);
        checks++;
        if (to || res !== 32'hFFFF_FFF9) begin
            failures++;
            $display("FAIL mul_neg1x7: got %h required fffffff9 (timeout=%0d)", res, to);
        end
        checks++;
        if (lat !== 34) begin
            failures++;
            $display("FAIL mul_latency: got %0d required 34", lat);
        end
        do_op(OP_MUL, 32'd12345, 32'd6789, res, lat, to);
        checks++;
        if (to || res !== 32'd83810205) begin
            failures++;
            $display("FAIL mul_12345x6789: got %0d required 83810205", res);
        end
        do_op(OP_MUL, 32'd0, 32'd5, res, lat, to);
        checks++;
        if (to || res !== 32'h0 || lat !== 34) begin
            failures++;
            $display("FAIL mul_zero: got %h lat %0d required 00000000 lat 34", res, lat);
        end
    endtask

    task automatic test_mul_high();
        logic [31:0] res; int lat; bit to;
        do_op(OP_MULH, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, to);
        checks++;
        if (to || res !== 32'h0000_0000) begin
            failures++;
            $display("FAIL mulh: got %h required 00000000", res);
        end
        do_op(OP_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, to);
        checks++;
        if (to || res !== 32'h8000_0000) begin
            failures++;
            $display("FAIL mulhsu: got %h required 80000000", res);
        end
        do_op(OP_MULHU, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, to);
        checks++;
        if (to || res !== 32'h7FFF_FFFF) begin
            failures++;
            $display("FAIL mulhu: got %h required 7fffffff", res);
        end
    endtask

    task automatic test_div_zero();
        logic [31:0] res; int lat; bit to;
        do_op(OP_DIV, 32'd13, 32'd0, res, lat, to);
        checks++;
        if (to || res !== 32'hFFFF_FFFF || lat !== 1) begin
            failures++;
            $display("FAIL div_by_zero: got %h lat %0d required ffffffff lat 1", res, lat);
        end
        do_op(OP_REMU, 32'd13, 32'd0, res, lat, to);
        checks++;
        if (to || res !== 32'd13 || lat !== 1) begin
            failures++;
            $display("FAIL remu_by_zero: got %h lat %0d required 0000000d lat 1", res, lat);
        end
        do_op(OP_REM, 32'hFFFF_FFFB, 32'd0, res, lat, to);
        checks++;
        if (to || res !== 32'hFFFF_FFFB) begin
            failures++;
            $display("FAIL rem_by_zero: got %h required fffffffb", res);
        end
    endtask

    task automatic test_signed_div();
        logic [31:0] res; int lat; bit to;
        do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, to);
        checks++;
        if (to || res !== 32'h8000_0000 || lat !== 1) begin
            failures++;
            $display("FAIL div_overflow: got %h lat %0d required 80000000 lat 1", res, lat);
        end
        do_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, to);
        checks++;
        if (to || res !== 32'h0) begin
            failures++;
            $display("FAIL rem_overflow: got %h required 00000000", res);
        end
        do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, res, lat, to);
        checks++;
        if (to || res !== 32'hFFFF_FFFD || lat !== 34) begin
            failures++;
            $display("FAIL div_m7_2: got %h lat %0d required fffffffd lat 34", res, lat);
        end
        do_op(OP_REM, 32'hFFFF_FFF9, 32'd2, res, lat, to);
        checks++;
        if (to || res !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL rem_m7_2: got %h required ffffffff", res);
        end
        do_op(OP_REMU, 32'd100, 32'd7, res, lat, to);
        checks++;
        if (to || res !== 32'd2) begin
            failures++;
            $display("FAIL remu_100_7: got %0d required 2", res);
        end
        checks++;
        if (result !== 32'd2) begin
            failures++;
            $display("FAIL result_hold_after_handshake: got %h required 00000002", result);
        end
    endtask

    task automatic test_back_to_back();
        int  n;
        bit  stable;
        @(negedge clk);
        in_valid = 1'b1; op_select = OP_DIVU; op1 = 32'd100; op2 = 32'd7; out_ready = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
        checks++;
        if (!out_valid || result !== 32'd14) begin
            failures++;
            $display("FAIL bp_first_result: out_valid=%b result=%h required 1/0000000e", out_valid, result);
        end
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || result !== 32'd14 || in_ready !== 1'b0) stable = 1'b0;
        end
        checks++;
        if (!stable) begin
            failures++;
            $display("FAIL bp_hold: out_valid=%b result=%h in_ready=%b required 1/0000000e/0",
                     out_valid, result, in_ready);
        end
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; op_select = OP_MUL; op1 = 32'd3; op2 = 32'd4;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_in_ready_done: got %b required 1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_same_cycle_accept: busy=%b out_valid=%b required 1/0", busy, out_valid);
        end
        n = 1;
        while (!out_valid && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
        checks++;
        if (!out_valid || result !== 32'd12 || n !== 34) begin
            failures++;
            $display("FAIL bp_second_result: result=%h lat %0d required 0000000c lat 34", result, n);
        end
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_flush();
        logic [31:0] res; int lat; bit to; int rises;
        @(negedge clk);
        in_valid = 1'b1; op_select = OP_DIVU; op1 = 32'd1000; op2 = 32'd3; out_ready = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_idle: busy=%b out_valid=%b in_ready=%b required 0/0/1",
                     busy, out_valid, in_ready);
        end
        rises = 0;
        repeat (40) begin
            @(posedge clk);
            #1 if (out_valid) rises++;
        end
        checks++;
        if (rises !== 0) begin
            failures++;
            $display("FAIL flush_no_result: out_valid high %0d cycles required 0", rises);
        end
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1; op_select = OP_DIVU; op1 = 32'd50; op2 = 32'd5;
        @(posedge clk);
        #1 in_valid = 1'b0; flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL flush_drops_accept: busy=%b required 0", busy);
        end
        do_op(OP_DIVU, 32'd100, 32'd7, res, lat, to);
        checks++;
        if (to || res !== 32'd14 || lat !== 34) begin
            failures++;
            $display("FAIL flush_then_divu: got %0d lat %0d required 14 lat 34", res, lat);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] res; int lat; bit to; int rises;
        @(negedge clk);
        in_valid = 1'b1; op_select = OP_DIVU; op1 = 32'd1000; op2 = 32'd3; out_ready = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || result !== 32'h0) begin
            failures++;
            $display("FAIL reset_abort: busy=%b out_valid=%b result=%h required 0/0/00000000",
                     busy, out_valid, result);
        end
        rises = 0;
        repeat (40) begin
            @(posedge clk);
            #1 if (out_valid) rises++;
        end
        checks++;
        if (rises !== 0) begin
            failures++;
            $display("FAIL reset_abort_no_result: out_valid high %0d cycles required 0", rises);
        end
        do_op(OP_DIVU, 32'd100, 32'd7, res, lat, to);
        checks++;
        if (to || res !== 32'd14) begin
            failures++;
            $display("FAIL reset_then_divu: got %0d required 14", res);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mul_high();
        test_div_zero();
        test_signed_div();
        test_back_to_back();
        test_flush();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_muldiv_unit
`default_nettype wire
